// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and the ALUOp/funct decoder for the EX-stage ALU.
package alu_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_NOP   = 6'b000000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
        logic       is_mul;
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [1:0] op,
                                            input logic [5:0] funct,
                                            input logic       mul_en);
        alu_dec_t d;
        d.ctrl    = ALU_NONE;
        d.illegal = 1'b0;
        d.is_mul  = 1'b0;
        case (op)
            ALUOP_MEM: d.ctrl = ALU_ADD;
            ALUOP_BEQ: d.ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.ctrl = ALU_ADD;
                    FUNCT_SUB: d.ctrl = ALU_SUB;
                    FUNCT_SLT: d.ctrl = ALU_SLT;
                    FUNCT_OR:  d.ctrl = ALU_OR;
                    FUNCT_AND: d.ctrl = ALU_AND;
                    FUNCT_NOR: d.ctrl = ALU_NOR;
                    FUNCT_XOR: d.ctrl = ALU_XOR;
                    FUNCT_MULTU: begin
                        if (mul_en) begin
                            d.ctrl   = ALU_MUL;
                            d.is_mul = 1'b1;
                        end else begin
                            d.illegal = 1'b1;
                        end
                    end
                    FUNCT_NOP: d.ctrl = ALU_NONE;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: the start cycle retires multiplier bit 0,
// each following cycle one more bit, so done pulses after exactly WIDTH bit steps.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;

    // Operand latch, partial-product accumulation and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_r <= {1'b0, b[WIDTH-1:1]};
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            cnt_r    <= CW'(1);
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            if (cnt_r == CW'(WIDTH-1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decodes ALUOp/funct, executes, and hands a registered result
// to writeback over a valid/ready pair; MULTU runs on the iterative multiplier.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic [3:0]       opout,
    output logic             illegal
);

    alu_state_e         state_r, state_s;
    alu_dec_t           dec_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               handshake_s;
    logic               load_single_s, load_mul_s;
    logic               mul_start_s, mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    logic               in_ready_r, out_valid_r, zero_r, illegal_r;
    logic [WIDTH-1:0]   result_r, result_hi_r;
    logic [3:0]         opout_r;

    assign dec_s       = alu_decode(op, funct, MUL_EN);
    assign handshake_s = in_valid & in_ready_r;
    assign mul_start_s = handshake_s & dec_s.is_mul;

    // Single-cycle datapath; illegal and NOP both decode to ALU_NONE and yield zero.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (dec_s.ctrl)
            ALU_ADD: alu_res_s = a + b;
            ALU_SUB: alu_res_s = a - b;
            ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OR:  alu_res_s = a | b;
            ALU_AND: alu_res_s = a & b;
            ALU_NOR: alu_res_s = ~(a | b);
            ALU_XOR: alu_res_s = a ^ b;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Next-state logic and result-capture strobes.
    always_comb begin
        state_s       = state_r;
        load_single_s = 1'b0;
        load_mul_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    if (dec_s.is_mul) begin
                        state_s = ST_MUL;
                    end else begin
                        state_s       = ST_DONE;
                        load_single_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_s    = ST_DONE;
                    load_mul_s = 1'b1;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers; results hold in DONE until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            opout_r     <= 4'b0000;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            if (load_single_s) begin
                result_r    <= alu_res_s;
                result_hi_r <= {WIDTH{1'b0}};
                zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                opout_r     <= dec_s.ctrl;
                illegal_r   <= dec_s.illegal;
            end else if (load_mul_s) begin
                result_r    <= mul_prod_s[WIDTH-1:0];
                result_hi_r <= mul_prod_s[2*WIDTH-1:WIDTH];
                zero_r      <= (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                opout_r     <= ALU_MUL;
                illegal_r   <= 1'b0;
            end else begin
                result_r    <= result_r;
                result_hi_r <= result_hi_r;
                zero_r      <= zero_r;
                opout_r     <= opout_r;
                illegal_r   <= illegal_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign zero      = zero_r;
    assign opout     = opout_r;
    assign illegal   = illegal_r;

endmodule
